// File: rtl/adder_if.sv
// Valid/ready operand and result bundle for pipelined_adder.
interface adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             of;

  // Producer/consumer side: drives operands and downstream ready.
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, of
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, of
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder: a + b + cin -> sum, cout, of.
// The carry chain is cut into STAGES chunks of WIDTH/STAGES bits, one register
// stage per chunk, with valid/ready flow control on both sides.
// Optional feature macro: ADDER_SAT_EN (saturate sum on signed overflow).
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input logic   clk,
  input logic   rst_n,
  adder_if.slave bus
);
  localparam int unsigned CHUNK = WIDTH / STAGES;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             of_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * CHUNK;      // first operand bit added here
    localparam int unsigned RW = WIDTH - LO;     // operand bits not yet added

    logic [RW-1:0]       a_i;
    logic [RW-1:0]       b_i;
    logic                c_i;
    logic                v_i;
    logic [CHUNK:0]      part;
    logic [LO+CHUNK-1:0] s_nx;
    logic                vld;
    logic                rdy;
    logic                rdy_dn;

    // Stage inputs: bus operands for stage 0, previous stage registers otherwise.
    if (k == 0) begin : g_src
      assign a_i  = bus.a;
      assign b_i  = bus.b;
      assign c_i  = bus.cin;
      assign v_i  = bus.in_valid;
      assign s_nx = part[CHUNK-1:0];
    end else begin : g_src
      assign a_i  = g_stage[k-1].g_reg.a_q;
      assign b_i  = g_stage[k-1].g_reg.b_q;
      assign c_i  = g_stage[k-1].g_reg.c_q;
      assign v_i  = g_stage[k-1].vld;
      assign s_nx = {part[CHUNK-1:0], g_stage[k-1].g_reg.s_q};
    end

    // Downstream ready: next stage, or the consumer for the last stage.
    if (k == STAGES - 1) begin : g_dn
      assign rdy_dn = bus.out_ready;
    end else begin : g_dn
      assign rdy_dn = g_stage[k+1].rdy;
    end

    // A stage may load when empty or when its content moves on this cycle.
    assign rdy  = !vld || rdy_dn;
    assign part = {1'b0, a_i[CHUNK-1:0]} + {1'b0, b_i[CHUNK-1:0]} + (CHUNK+1)'(c_i);

    // Stage occupancy; bubbles collapse because an empty stage is always ready.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= 1'b0;
      end else if (rdy) begin
        vld <= v_i;
      end
    end

    if (k < STAGES - 1) begin : g_reg
      logic [RW-CHUNK-1:0] a_q;
      logic [RW-CHUNK-1:0] b_q;
      logic [LO+CHUNK-1:0] s_q;
      logic                c_q;

      // Partial sum, chunk carry and skewed upper operand bits.
      always_ff @(posedge clk) begin
        if (rdy) begin
          a_q <= a_i[RW-1:CHUNK];
          b_q <= b_i[RW-1:CHUNK];
          s_q <= s_nx;
          c_q <= part[CHUNK];
        end
      end
    end else begin : g_out
      logic             msb_carry;
      logic             of_nx;
      logic [WIDTH-1:0] sum_nx;

      // Carry into the MSB recovered from the MSB sum bit; overflow when it differs from cout.
      assign msb_carry = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ part[CHUNK-1];
      assign of_nx     = msb_carry ^ part[CHUNK];

`ifdef ADDER_SAT_EN
      // Clamp to the signed limit on the side of operand a's sign.
      always_comb begin
        sum_nx = s_nx;
        if (of_nx) begin
          sum_nx = a_i[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
`else
      assign sum_nx = s_nx;
`endif

      // Result registers; held while the consumer stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          of_q   <= 1'b0;
        end else if (rdy) begin
          sum_q  <= sum_nx;
          cout_q <= part[CHUNK];
          of_q   <= of_nx;
        end
      end

      assign bus.out_valid = vld;
    end
  end

  assign bus.in_ready = g_stage[0].rdy;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.of       = of_q;
endmodule
